tl_rx_malformed_checker: RTL and testbench

Sequential, parametrised malformed-TLP checker for the TL RX write-handler error-check path. It captures a received TLP header, counts payload DWs beat by beat until end-of-packet, and applies all malformed rules in a single registered verdict per TLP. Relative to the earlier single-cycle combinational check, it adds:
- multi-VC traffic-class filtering;
- configurable beat width;
- payload-overrun detection;
- cause encoding, sticky status and a saturating error counter.

---
 rtl/tl_rx_malformed_checker_pkg.sv | 43 ++++
 rtl/tl_rx_malformed_checker_if.sv | 39 +++
 rtl/tl_rx_malformed_checker_mps_limit.sv | 19 +
 rtl/tl_rx_malformed_checker.sv | 145 ++++++++++++++
 tb/tb_tl_rx_malformed_checker.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_rx_malformed_checker_pkg.sv
// Shared encodings for the TL RX error-check path: TLP types, max-payload codes,
// malformed causes and the checker FSM states.
package tl_rx_err_pkg;

    typedef enum logic [2:0] {
        TYP_MEMORY        = 3'd0,
        TYP_IO            = 3'd1,
        TYP_COMPLETION    = 3'd2,
        TYP_CONFIGURATION = 3'd3,
        TYP_MESSAGE       = 3'd4
    } tlp_typ_e;

    typedef enum logic [2:0] {
        MPS_128  = 3'd2,
        MPS_256  = 3'd3,
        MPS_512  = 3'd4,
        MPS_1024 = 3'd5
    } mps_code_e;

    typedef enum logic [2:0] {
        CAUSE_NONE         = 3'd0,
        CAUSE_LEN_MISMATCH = 3'd1,
        CAUSE_MISSING_EOP  = 3'd2,
        CAUSE_BAD_TYPE     = 3'd3,
        CAUSE_TC_ATTR_AT   = 3'd4,
        CAUSE_SINGLE_DW    = 3'd5,
        CAUSE_MPS          = 3'd6
    } err_cause_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // Flag bit i corresponds to cause i; the lowest-numbered flagged cause wins.
    function automatic logic [2:0] first_cause(input logic [6:0] flags);
        first_cause = CAUSE_NONE;
        for (int i = 6; i >= 1; i--) begin
            if (flags[i]) first_cause = 3'(i);
        end
    endfunction

endpackage

// File: rtl/tl_rx_malformed_checker_if.sv
// Header, payload-beat and verdict/status signals of the malformed-TLP checker.
interface tl_rx_malformed_checker_if #(
    parameter int DATA_WIDTH = 10,
    parameter int BEAT_DW    = 8,
    parameter int CNT_W      = 8
);
    logic                          malformed_en;
    logic                          hdr_valid;
    logic                          has_data;
    logic [2:0]                    typ;
    logic [DATA_WIDTH-1:0]         Length;
    logic [2:0]                    TC;
    logic [1:0]                    Attr;
    logic [1:0]                    AT;
    logic [2:0]                    max_payload_config;
    logic [7:0]                    tc_enable;
    logic                          data_valid;
    logic [$clog2(BEAT_DW+1)-1:0]  data_dw;
    logic                          eop;
    logic                          err_status_clr;
    logic                          busy;
    logic                          chk_done;
    logic                          malformed_error;
    logic [2:0]                    err_cause;
    logic [6:0]                    err_status;
    logic [CNT_W-1:0]              err_count;

    modport master (
        output malformed_en, hdr_valid, has_data, typ, Length, TC, Attr, AT,
               max_payload_config, tc_enable, data_valid, data_dw, eop, err_status_clr,
        input  busy, chk_done, malformed_error, err_cause, err_status, err_count
    );

    modport slave (
        input  malformed_en, hdr_valid, has_data, typ, Length, TC, Attr, AT,
               max_payload_config, tc_enable, data_valid, data_dw, eop, err_status_clr,
        output busy, chk_done, malformed_error, err_cause, err_status, err_count
    );
endinterface

// File: rtl/tl_rx_malformed_checker_mps_limit.sv
// Maps a max_payload_config code to its payload limit in DW; shared with the completion checker.
module tl_rx_mps_limit
    import tl_rx_err_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic [2:0]          i_cfg,
    output logic [DATA_WIDTH:0] o_limit
);
    always_comb begin
        case (i_cfg)
            MPS_128:  o_limit = (DATA_WIDTH+1)'(128);
            MPS_256:  o_limit = (DATA_WIDTH+1)'(256);
            MPS_512:  o_limit = (DATA_WIDTH+1)'(512);
            MPS_1024: o_limit = (DATA_WIDTH+1)'(1024);
            default:  o_limit = (DATA_WIDTH+1)'(32);
        endcase
    end
endmodule

// File: rtl/tl_rx_malformed_checker.sv
// Sequential malformed-TLP checker: captures a header, tracks payload DWs until eop and
// issues one registered verdict per TLP with cause, sticky status and a saturating count.
module tl_rx_malformed_checker
    import tl_rx_err_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int BEAT_DW    = 8,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    tl_rx_malformed_checker_if.slave  bus
);
    localparam int DDW = $clog2(BEAT_DW+1);

    logic [1:0]            r_state;
    logic                  r_en;
    logic [DATA_WIDTH:0]   r_len_exp;
    logic [DATA_WIDTH:0]   r_dw_acc;
    logic [6:0]            r_flags;
    logic                  r_busy;
    logic                  r_chk_done;
    logic                  r_mal;
    logic [2:0]            r_cause;
    logic [6:0]            r_status;
    logic [CNT_W-1:0]      r_count;

    logic [DDW-1:0]        w_beat_dw;
    logic [DATA_WIDTH:0]   w_hdr_len, w_mps_limit, w_base, w_exp, w_acc_n, w_len_n;
    logic [DATA_WIDTH+1:0] w_sum;
    logic [6:0]            w_static, w_flags_n, w_set;
    logic [1:0]            w_state_n;
    logic                  w_en_n, w_capture, w_beat, w_report;
    logic [2:0]            w_cause;

    tl_rx_mps_limit #(.DATA_WIDTH(DATA_WIDTH)) u_mps_limit (
        .i_cfg   (bus.max_payload_config),
        .o_limit (w_mps_limit)
    );

    // A Length field of zero encodes the full 2^DATA_WIDTH DW payload.
    assign w_hdr_len = (bus.Length == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, bus.Length};
    assign w_beat_dw = bus.data_dw;
    assign w_capture = (r_state == ST_IDLE) && bus.hdr_valid;
    assign w_base    = w_capture ? '0 : r_dw_acc;
    assign w_exp     = w_capture ? w_hdr_len : r_len_exp;
    assign w_sum     = {1'b0, w_base} + (DATA_WIDTH+2)'(w_beat_dw);
    assign w_beat    = bus.data_valid &&
                       ((w_capture && bus.has_data) || (r_state == ST_DATA && !bus.hdr_valid));

    always_comb begin
        w_static = '0;
        w_static[CAUSE_BAD_TYPE]   = (bus.typ > TYP_MESSAGE);
        w_static[CAUSE_TC_ATTR_AT] = !bus.tc_enable[bus.TC] || (bus.Attr != 2'b00) || (bus.AT != 2'b00);
        w_static[CAUSE_SINGLE_DW]  = ((bus.typ == TYP_IO) || (bus.typ == TYP_CONFIGURATION)) &&
                                     (bus.Length != DATA_WIDTH'(1));
        w_static[CAUSE_MPS]        = (w_hdr_len > w_mps_limit);
    end

    always_comb begin
        w_state_n = r_state;
        w_flags_n = r_flags;
        w_acc_n   = r_dw_acc;
        w_len_n   = r_len_exp;
        w_en_n    = r_en;
        case (r_state)
            ST_IDLE: begin
                if (bus.hdr_valid) begin
                    w_flags_n = w_static;
                    w_len_n   = w_hdr_len;
                    w_acc_n   = '0;
                    w_en_n    = bus.malformed_en;
                    w_state_n = bus.has_data ? ST_DATA : ST_REPORT;
                end
            end
            ST_DATA: begin
                if (bus.hdr_valid) begin
                    w_flags_n[CAUSE_MISSING_EOP] = 1'b1;
                    w_state_n = ST_REPORT;
                end
            end
            ST_DRAIN: begin
                if (bus.hdr_valid || (bus.data_valid && bus.eop)) w_state_n = ST_REPORT;
            end
            default: w_state_n = ST_IDLE;
        endcase
        // The beat in a header cycle is evaluated against the header being captured.
        if (w_beat) begin
            if (bus.eop) begin
                if (w_sum != {1'b0, w_exp}) w_flags_n[CAUSE_LEN_MISMATCH] = 1'b1;
                w_state_n = ST_REPORT;
            end else if (w_sum > {1'b0, w_exp}) begin
                w_flags_n[CAUSE_LEN_MISMATCH] = 1'b1;
                w_state_n = ST_DRAIN;
            end else begin
                w_acc_n = w_sum[DATA_WIDTH:0];
            end
        end
    end

    assign w_report = (w_state_n == ST_REPORT) && (r_state != ST_REPORT);
    assign w_cause  = w_en_n ? first_cause(w_flags_n) : CAUSE_NONE;

    always_comb begin
        w_set = '0;
        if (w_report && (w_cause != CAUSE_NONE)) w_set[w_cause] = 1'b1;
    end

    // The verdict, status and counter all land on the edge that enters REPORT.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_len_exp  <= '0;
            r_dw_acc   <= '0;
            r_flags    <= '0;
            r_busy     <= 1'b0;
            r_chk_done <= 1'b0;
            r_mal      <= 1'b0;
            r_cause    <= '0;
            r_status   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_en       <= w_en_n;
            r_len_exp  <= w_len_n;
            r_dw_acc   <= w_acc_n;
            r_flags    <= w_flags_n;
            r_busy     <= (w_state_n != ST_IDLE);
            r_chk_done <= w_report;
            r_mal      <= w_report && (w_cause != CAUSE_NONE);
            r_cause    <= w_report ? w_cause : 3'd0;
            r_status   <= (bus.err_status_clr ? 7'd0 : r_status) | w_set;
            if (w_report && (w_cause != CAUSE_NONE) && (r_count != '1)) r_count <= r_count + 1'b1;
        end
    end

    assign bus.busy            = r_busy;
    assign bus.chk_done        = r_chk_done;
    assign bus.malformed_error = r_mal;
    assign bus.err_cause       = r_cause;
    assign bus.err_status      = r_status;
    assign bus.err_count       = r_count;

endmodule

// File: tb/tb_tl_rx_malformed_checker.sv
// Self-checking bench for tl_rx_malformed_checker: directed plan items plus randomized
// TLPs scored against a transaction-level model of the malformed rules.
module tb_tl_rx_malformed_checker;

    localparam int DW = 10;
    localparam int BD = 8;
    localparam int CW = 8;

    typedef struct {
        bit         en;
        int         typ;
        int         len;
        int         tc;
        int         attr;
        int         at;
        int         mps;
        logic [7:0] tcen;
        bit         hasData;
        bit         hdrBeat;
        bit         interrupt;
        int         sendBeats;
        bit         clr;
    } tlp_t;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] expStatus = 7'd0;
    int   expCount = 0;
    int   beats[$];

    always #5 clk = ~clk;

    tl_rx_malformed_checker_if #(.DATA_WIDTH(DW), .BEAT_DW(BD), .CNT_W(CW)) bus ();

    tl_rx_malformed_checker #(.DATA_WIDTH(DW), .BEAT_DW(BD), .CNT_W(CW)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // Every comparison in the bench funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.malformed_en = 1'b0; bus.hdr_valid = 1'b0; bus.has_data = 1'b0;
        bus.typ = 3'd0; bus.Length = '0; bus.TC = 3'd0; bus.Attr = 2'd0; bus.AT = 2'd0;
        bus.max_payload_config = 3'd0; bus.tc_enable = 8'h00;
        bus.data_valid = 1'b0; bus.data_dw = '0; bus.eop = 1'b0; bus.err_status_clr = 1'b0;
    endtask

    task automatic driveBeat(input int dw, input bit last);
        bus.data_valid = 1'b1;
        bus.data_dw    = 4'(dw);
        bus.eop        = last;
    endtask

    function automatic int mpsLimit(input int cfg);
        case (cfg)
            2: return 128;
            3: return 256;
            4: return 512;
            5: return 1024;
            default: return 32;
        endcase
    endfunction

    // Verdict of one whole TLP from its header and the total DWs that were delivered.
    function automatic int expectedCause(input tlp_t t, input int sentTotal);
        int expLen = (t.len == 0) ? 1024 : t.len;
        bit [6:0] f = '0;
        if (t.hasData) begin
            if (t.interrupt) begin
                f[1] = (sentTotal > expLen);
                f[2] = 1'b1;
            end else begin
                f[1] = (sentTotal != expLen);
            end
        end
        f[3] = (t.typ > 4);
        f[4] = (t.tcen[t.tc] == 1'b0) || (t.attr != 0) || (t.at != 0);
        f[5] = ((t.typ == 1) || (t.typ == 3)) && (t.len != 1);
        f[6] = (expLen > mpsLimit(t.mps));
        if (!t.en) return 0;
        for (int i = 1; i <= 6; i++) if (f[i]) return i;
        return 0;
    endfunction

    function automatic tlp_t mkTlp();
        tlp_t t;
        t.en = 1'b1; t.typ = 0; t.len = 16; t.tc = 0; t.attr = 0; t.at = 0; t.mps = 5;
        t.tcen = 8'hFF; t.hasData = 1'b1; t.hdrBeat = 1'b0; t.interrupt = 1'b0;
        t.sendBeats = 0; t.clr = 1'b0;
        return t;
    endfunction

    // Plays one TLP (header, beats from the beats queue, optional interrupting header)
    // and scores the verdict cycle and the following return to idle.
    task automatic applyStimulus(input tlp_t t, input string tag);
        int n    = t.interrupt ? t.sendBeats : beats.size();
        int idx  = 0;
        int sent = 0;
        int cause;
        bus.hdr_valid = 1'b1; bus.malformed_en = t.en; bus.has_data = t.hasData;
        bus.typ = 3'(t.typ); bus.Length = 10'(t.len); bus.TC = 3'(t.tc);
        bus.Attr = 2'(t.attr); bus.AT = 2'(t.at); bus.max_payload_config = 3'(t.mps);
        bus.tc_enable = t.tcen; bus.err_status_clr = t.clr;
        if (t.hasData && t.hdrBeat && n > 0) begin
            driveBeat(beats[0], (n == 1) && !t.interrupt);
            sent += beats[0];
            idx = 1;
        end
        tick();
        bus.hdr_valid = 1'b0; bus.data_valid = 1'b0; bus.eop = 1'b0;
        if (t.hasData) begin
            while (idx < n) begin
                driveBeat(beats[idx], (idx == n - 1) && !t.interrupt);
                sent += beats[idx];
                idx++;
                tick();
                bus.data_valid = 1'b0; bus.eop = 1'b0;
            end
            if (t.interrupt) begin
                bus.hdr_valid = 1'b1;
                bus.typ       = 3'($urandom_range(0, 7));
                bus.has_data  = 1'($urandom_range(0, 1));
                tick();
                bus.hdr_valid = 1'b0;
            end
        end
        cause = expectedCause(t, sent);
        if (t.clr) expStatus = 7'd0;
        if (cause != 0) begin
            expStatus[cause] = 1'b1;
            if (expCount < 255) expCount++;
        end
        checkOutput({tag, ".chk_done"}, bus.chk_done, 1);
        checkOutput({tag, ".busy_report"}, bus.busy, 1);
        checkOutput({tag, ".malformed_error"}, bus.malformed_error, (cause != 0) ? 1 : 0);
        checkOutput({tag, ".err_cause"}, bus.err_cause, cause);
        checkOutput({tag, ".err_status"}, bus.err_status, expStatus);
        checkOutput({tag, ".err_count"}, bus.err_count, expCount);
        bus.err_status_clr = 1'b0;
        bus.data_valid = 1'($urandom_range(0, 1));
        bus.data_dw    = 4'($urandom_range(1, BD));
        bus.eop        = 1'($urandom_range(0, 1));
        tick();
        bus.data_valid = 1'b0; bus.eop = 1'b0;
        checkOutput({tag, ".chk_done_pulse"}, bus.chk_done, 0);
        checkOutput({tag, ".busy_idle"}, bus.busy, 0);
    endtask

    task automatic fillBeats(input int total);
        int remaining = total;
        int c;
        beats.delete();
        while (remaining > 0) begin
            c = $urandom_range(1, (remaining < BD) ? remaining : BD);
            beats.push_back(c);
            remaining -= c;
        end
    endtask

    // Safety net so a stuck design can never hang the run.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tlp_t t;
        int   bnd[7] = '{1, 32, 33, 128, 129, 256, 257};
        int   expLen;
        int   total;
        int   r;

        clearInputs();
        repeat (3) tick();
        checkOutput("reset.busy", bus.busy, 0);
        checkOutput("reset.chk_done", bus.chk_done, 0);
        checkOutput("reset.malformed_error", bus.malformed_error, 0);
        checkOutput("reset.err_cause", bus.err_cause, 0);
        checkOutput("reset.err_status", bus.err_status, 0);
        checkOutput("reset.err_count", bus.err_count, 0);
        arst = 1'b1;
        tick();

        t = mkTlp(); beats = {8, 8};
        applyStimulus(t, "mem_ok");
        t = mkTlp(); beats = {8, 8, 4, 1};
        applyStimulus(t, "mem_overrun");
        t = mkTlp(); t.typ = 1; t.len = 2; beats = {2};
        applyStimulus(t, "io_single_dw");
        t.tc = 3; t.tcen = 8'h01;
        applyStimulus(t, "io_tc_prio");
        t = mkTlp(); t.mps = 2; t.len = 200;
        beats.delete(); repeat (25) beats.push_back(8);
        applyStimulus(t, "mps_200");
        t.en = 1'b0;
        applyStimulus(t, "mps_disabled");
        t = mkTlp(); beats = {8, 8}; t.interrupt = 1'b1; t.sendBeats = 1;
        applyStimulus(t, "hdr_in_data");
        t = mkTlp(); t.len = 4; t.hdrBeat = 1'b1; beats = {4};
        applyStimulus(t, "hdr_cycle_eop");
        t = mkTlp(); t.hasData = 1'b0; t.typ = 5;
        applyStimulus(t, "bad_type");
        t = mkTlp(); t.hasData = 1'b0; t.len = 0;
        applyStimulus(t, "len0_mps1024");
        t.mps = 4;
        applyStimulus(t, "len0_mps512");
        t = mkTlp(); t.hasData = 1'b0; t.mps = 2; t.len = 128;
        applyStimulus(t, "mps_edge_128");
        t.len = 129;
        applyStimulus(t, "mps_edge_129");
        t = mkTlp(); t.hasData = 1'b0; t.typ = 3; t.len = 1;
        applyStimulus(t, "cfg_len1");

        // Reset in the middle of a TLP: no verdict, everything back to zero.
        t = mkTlp();
        bus.hdr_valid = 1'b1; bus.malformed_en = 1'b1; bus.has_data = 1'b1;
        bus.Length = 10'd16; bus.tc_enable = 8'hFF; bus.max_payload_config = 3'd5;
        tick();
        bus.hdr_valid = 1'b0;
        driveBeat(8, 1'b0);
        tick();
        arst = 1'b0;
        #2;
        expStatus = 7'd0; expCount = 0;
        checkOutput("midreset.busy", bus.busy, 0);
        checkOutput("midreset.err_status", bus.err_status, 0);
        checkOutput("midreset.err_count", bus.err_count, 0);
        #1 arst = 1'b1;
        driveBeat(8, 1'b1);
        tick();
        bus.data_valid = 1'b0; bus.eop = 1'b0;
        checkOutput("midreset.no_verdict", bus.chk_done, 0);
        checkOutput("midreset.idle", bus.busy, 0);

        for (int k = 0; k < 150; k++) begin
            t = mkTlp();
            t.en   = ($urandom_range(0, 9) != 0);
            t.typ  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            if (r < 6)       t.len = $urandom_range(1, 48);
            else if (r < 8)  t.len = bnd[$urandom_range(0, 6)];
            else if (r == 8) t.len = 0;
            else             t.len = $urandom_range(1, 1023);
            if (((t.typ == 1) || (t.typ == 3)) && ($urandom_range(0, 1) == 1)) t.len = 1;
            t.tc   = $urandom_range(0, 7);
            t.tcen = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            t.attr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            t.at   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            t.mps  = $urandom_range(0, 7);
            t.hasData = 1'($urandom_range(0, 1));
            t.hdrBeat = 1'($urandom_range(0, 1));
            t.clr     = ($urandom_range(0, 7) == 0);
            beats.delete();
            if (t.hasData) begin
                expLen = (t.len == 0) ? 1024 : t.len;
                r = $urandom_range(0, 5);
                if (r == 0)      total = expLen + $urandom_range(1, 9);
                else if (r == 1) total = expLen - $urandom_range(1, 5);
                else             total = expLen;
                if (total < 1) total = 1;
                fillBeats(total);
                t.interrupt = ($urandom_range(0, 5) == 0);
                t.sendBeats = $urandom_range(0, beats.size() - 1);
            end
            applyStimulus(t, "random");
        end

        t = mkTlp(); t.hasData = 1'b0; t.typ = 6;
        for (int k = 0; k < 260; k++) applyStimulus(t, "saturate");
        checkOutput("saturate.count_max", bus.err_count, 255);

        t = mkTlp(); t.hasData = 1'b0; t.typ = 1; t.len = 2;
        applyStimulus(t, "pre_clear");
        t = mkTlp(); t.hasData = 1'b0; t.typ = 7; t.clr = 1'b1;
        applyStimulus(t, "clear_vs_set");
        checkOutput("clear_vs_set.exact", bus.err_status, 7'b0001000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
